// File: rtl/instruction_fetch.sv
// instruction_fetch: PC/fetch stage with IF/ID register, stall/flush/redirect, EBREAK halt (optional macro FETCH_MISALIGN_CHECK_EN)
module instruction_fetch #(
   parameter int                DWIDTH    = 32,
   parameter logic [DWIDTH-1:0] RESET_PC  = 32'h0000_0000,
   parameter logic [DWIDTH-1:0] NOP_INSTR = 32'h0000_0013
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              stall,
   input  logic              flush,
   input  logic              redirect_valid,
   input  logic [DWIDTH-1:0] redirect_pc,
   output logic [DWIDTH-1:0] imem_addr,
   input  logic [DWIDTH-1:0] imem_rdata,
   output logic              ifid_valid,
   output logic [DWIDTH-1:0] ifid_pc,
   output logic [DWIDTH-1:0] ifid_pc_plus4,
   output logic [DWIDTH-1:0] ifid_instr,
   output logic              halted,
   output logic [31:0]       fetch_count
`ifdef FETCH_MISALIGN_CHECK_EN
   ,
   output logic              misalign_err
`endif
);
   localparam logic [DWIDTH-1:0] EBREAK = DWIDTH'(32'h0010_0073);
   typedef enum logic [1:0] {BOOT, RUN, HALT} state_t;
   state_t            r_state, w_state_nxt;
   logic [DWIDTH-1:0] r_pc, r_ifid_pc, r_ifid_pc_plus4, r_ifid_instr;
   logic              r_ifid_valid;
   logic [31:0]       r_fetch_count;
   logic              w_redir, w_fetch, w_hold, w_bad;
`ifdef FETCH_MISALIGN_CHECK_EN
   logic              r_misalign_err;
   assign w_bad        = redirect_pc[1:0] != 2'b00;
   assign misalign_err = r_misalign_err;
`else
   assign w_bad = 1'b0;
`endif
   assign imem_addr     = r_pc;
   assign ifid_valid    = r_ifid_valid;
   assign ifid_pc       = r_ifid_pc;
   assign ifid_pc_plus4 = r_ifid_pc_plus4;
   assign ifid_instr    = r_ifid_instr;
   assign fetch_count   = r_fetch_count;
   assign halted        = r_state == HALT;
   // Decode this cycle's action in priority order redirect > flush > stall > fetch
   always_comb begin
      w_redir     = redirect_valid && r_state != BOOT;
      w_fetch     = r_state == RUN && !redirect_valid && !flush && !stall;
      w_hold      = r_state == RUN && !redirect_valid && !flush && stall;
      w_state_nxt = r_state == BOOT ? RUN :
                    w_redir ? (w_bad ? HALT : RUN) :
                    (w_fetch && imem_rdata == EBREAK) ? HALT : r_state;
   end
   // FSM state register
   always_ff @(posedge clk) r_state <= rst ? BOOT : w_state_nxt;
   // PC, IF/ID pipeline register and retired-fetch counter
   always_ff @(posedge clk) begin
      if (rst) begin
         r_pc            <= RESET_PC;
         r_ifid_valid    <= 1'b0;
         r_ifid_pc       <= '0;
         r_ifid_pc_plus4 <= '0;
         r_ifid_instr    <= NOP_INSTR;
         r_fetch_count   <= '0;
      end else begin
         r_pc         <= w_redir ? redirect_pc : w_fetch ? r_pc + DWIDTH'(4) : r_pc;
         r_ifid_valid <= w_fetch | (w_hold & r_ifid_valid);
         if (w_fetch) begin
            r_ifid_instr    <= imem_rdata;
            r_ifid_pc       <= r_pc;
            r_ifid_pc_plus4 <= r_pc + DWIDTH'(4);
            r_fetch_count   <= r_fetch_count + 32'd1;
         end
      end
   end
`ifdef FETCH_MISALIGN_CHECK_EN
   // Sticky flag for a taken redirect to a non-word-aligned target
   always_ff @(posedge clk) r_misalign_err <= rst ? 1'b0 : (r_misalign_err | (w_redir & w_bad));
`endif
endmodule

// File: tb/tb_instruction_fetch.sv
// tb_instruction_fetch: directed plan plus randomized traffic against a behavioural fetch model
module tb_instruction_fetch;
   localparam logic [31:0] EBREAK = 32'h0010_0073;
   logic        clk = 1'b0;
   logic        rst, stall, flush, redirect_valid;
   logic [31:0] redirect_pc, imem_addr, imem_rdata, ifid_pc, ifid_pc_plus4, ifid_instr, fetch_count;
   logic        ifid_valid, halted;
   logic [31:0] mem [0:63];
   int          checks = 0, errors = 0;
`ifdef FETCH_MISALIGN_CHECK_EN
   logic        misalign_err;
`endif

   instruction_fetch dut (
      .clk(clk), .rst(rst), .stall(stall), .flush(flush),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .imem_addr(imem_addr), .imem_rdata(imem_rdata),
      .ifid_valid(ifid_valid), .ifid_pc(ifid_pc), .ifid_pc_plus4(ifid_pc_plus4),
      .ifid_instr(ifid_instr), .halted(halted), .fetch_count(fetch_count)
`ifdef FETCH_MISALIGN_CHECK_EN
      , .misalign_err(misalign_err)
`endif
   );

   always #5 clk = ~clk;
   assign imem_rdata = mem[6'((imem_addr >> 2) & 32'h3F)];

   // behavioural model: the fetch stage as plain per-cycle rules
   logic        m_live = 1'b0, m_boot, m_halt, m_valid, m_err;
   logic [31:0] m_pc, m_ipc, m_p4, m_instr, m_cnt, m_w;
   always @(posedge clk) begin
      if (rst) begin
         m_live = 1; m_boot = 1; m_halt = 0; m_valid = 0; m_err = 0;
         m_pc = 0; m_ipc = 0; m_p4 = 0; m_instr = 32'h13; m_cnt = 0;
      end else if (m_live) begin
         if (m_boot) begin
            m_boot = 0; m_valid = 0;
         end else if (redirect_valid) begin
            m_pc = redirect_pc; m_valid = 0; m_halt = 0;
`ifdef FETCH_MISALIGN_CHECK_EN
            if (redirect_pc % 4 != 0) begin m_err = 1; m_halt = 1; end
`endif
         end else if (m_halt || flush) begin
            m_valid = 0;
         end else if (!stall) begin
            m_w = mem[m_pc[7:2]];
            m_instr = m_w; m_ipc = m_pc; m_p4 = m_pc + 4; m_valid = 1;
            m_pc = m_pc + 4; m_cnt = m_cnt + 1;
            if (m_w == EBREAK) m_halt = 1;
         end
      end
   end

   task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
      checks++;
      if (a !== e) begin
         errors++;
         $display("FAIL %s: got %h expected %h", n, a, e);
      end
   endtask

   // every cycle after the first reset, all outputs must match the model
   always @(negedge clk) if (m_live) begin
      chk("imem_addr", imem_addr, m_pc);
      chk("ifid_valid", 32'(ifid_valid), 32'(m_valid));
      chk("ifid_pc", ifid_pc, m_ipc);
      chk("ifid_pc_plus4", ifid_pc_plus4, m_p4);
      chk("ifid_instr", ifid_instr, m_instr);
      chk("halted", 32'(halted), 32'(m_halt));
      chk("fetch_count", fetch_count, m_cnt);
`ifdef FETCH_MISALIGN_CHECK_EN
      chk("misalign_err", 32'(misalign_err), 32'(m_err));
`endif
   end

   task automatic cyc(input logic rs, input logic st, input logic fl, input logic rv, input logic [31:0] rpc);
      rst = rs; stall = st; flush = fl; redirect_valid = rv; redirect_pc = rpc;
      @(posedge clk);
      @(negedge clk);
   endtask

   initial begin
      rst = 1; stall = 0; flush = 0; redirect_valid = 0; redirect_pc = 0;
      for (int i = 0; i < 64; i++) mem[i] = 32'h13;
      mem[0] = 32'h0050_0093; mem[1] = 32'h0010_0113; mem[4] = EBREAK;
      cyc(1, 0, 0, 0, 0); cyc(1, 0, 0, 0, 0);
      chk("rst valid", 32'(ifid_valid), 0); chk("rst instr", ifid_instr, 32'h13);
      chk("rst addr", imem_addr, 0); chk("rst count", fetch_count, 0);
      cyc(0, 0, 0, 0, 0);
      chk("boot bubble", 32'(ifid_valid), 0); chk("boot addr", imem_addr, 0);
      cyc(0, 0, 0, 0, 0);
      chk("f0 valid", 32'(ifid_valid), 1); chk("f0 pc", ifid_pc, 0); chk("f0 instr", ifid_instr, 32'h0050_0093);
      cyc(0, 0, 0, 0, 0);
      chk("f1 pc", ifid_pc, 4); chk("f1 count", fetch_count, 2); chk("f1 addr", imem_addr, 8);
      repeat (3) cyc(0, 1, 0, 0, 0);
      chk("stall addr", imem_addr, 8); chk("stall pc", ifid_pc, 4); chk("stall count", fetch_count, 2);
      cyc(0, 0, 0, 0, 0);
      chk("release pc", ifid_pc, 8); chk("release count", fetch_count, 3);
      cyc(0, 1, 1, 1, 32'h40);
      chk("redir valid", 32'(ifid_valid), 0); chk("redir addr", imem_addr, 32'h40); chk("redir count", fetch_count, 3);
      cyc(0, 0, 0, 0, 0);
      chk("redir fetch pc", ifid_pc, 32'h40);
      cyc(0, 0, 0, 1, 32'h10);
      cyc(0, 0, 0, 0, 0);
      chk("ebreak valid", 32'(ifid_valid), 1); chk("ebreak instr", ifid_instr, EBREAK);
      chk("ebreak halted", 32'(halted), 1); chk("ebreak addr", imem_addr, 32'h14);
      cyc(0, 0, 0, 0, 0);
      chk("halt valid", 32'(ifid_valid), 0);
      cyc(0, 1, 1, 0, 0);
      chk("halt addr", imem_addr, 32'h14); chk("halt count", fetch_count, 5);
      cyc(0, 0, 0, 1, 0);
      chk("resume halted", 32'(halted), 0); chk("resume addr", imem_addr, 0);
      cyc(0, 0, 0, 0, 0);
      chk("resume pc", ifid_pc, 0);
      cyc(0, 0, 0, 1, 32'hFFFF_FFFC);
      cyc(0, 0, 0, 0, 0);
      chk("wrap pc", ifid_pc, 32'hFFFF_FFFC); chk("wrap plus4", ifid_pc_plus4, 0); chk("wrap addr", imem_addr, 0);
`ifdef FETCH_MISALIGN_CHECK_EN
      cyc(0, 0, 0, 1, 32'h42);
      chk("misalign err", 32'(misalign_err), 1); chk("misalign halted", 32'(halted), 1);
      cyc(1, 0, 0, 0, 0);
      chk("misalign clr", 32'(misalign_err), 0); chk("misalign halt clr", 32'(halted), 0);
      chk("misalign rst addr", imem_addr, 0); chk("misalign rst instr", ifid_instr, 32'h13);
`endif
      for (int i = 0; i < 64; i++) mem[i] = ($urandom_range(0, 9) == 0) ? EBREAK : $urandom;
      cyc(1, 0, 0, 0, 0);
      for (int n = 0; n < 3000; n++)
         cyc($urandom_range(0, 63) == 0, $urandom_range(0, 3) == 0, $urandom_range(0, 7) == 0,
             $urandom_range(0, 15) == 0,
             ($urandom_range(0, 7) == 0) ? $urandom : {24'h0, 6'($urandom), 2'b00});
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/instruction_fetch.md
Name: instruction_fetch

Overview:
- PC/fetch stage directly upstream of instruction_memory. Drives the word address and captures the combinational read data into an IF/ID pipeline register.
- Handles stall, flush and branch/jump redirect from downstream stages.
- Halts on EBREAK.
- Maintains a retired-fetch counter for debug and performance use.

Parameters:
- DWIDTH, 32, width of PC, address and instruction words.
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- NOP_INSTR, 32'h0000_0013, value (ADDI x0,x0,0) loaded into ifid_instr on reset.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- stall  input  1  hold PC, IF/ID register and counter.
- flush  input  1  invalidate IF/ID contents.
- redirect_valid  input  1  load PC from redirect_pc.
- redirect_pc  input  DWIDTH  redirect target byte address.
- imem_addr  output  DWIDTH  byte address to instruction_memory addr; equals pc.
- imem_rdata  input  DWIDTH  instruction_memory data_out; combinational, same cycle.
- ifid_valid  output  1  IF/ID register holds a valid instruction.
- ifid_pc  output  DWIDTH  PC of the captured instruction.
- ifid_pc_plus4  output  DWIDTH  ifid_pc+4, registered.
- ifid_instr  output  DWIDTH  captured instruction.
- halted  output  1  FSM is in HALT.
- fetch_count  output  32  count of instructions captured with valid=1.

Behaviour:
- Single clock; all state updates on posedge clk; rst is synchronous, active-high.
- imem_addr = pc, combinational.
- Reset values:
  - pc=RESET_PC, state=BOOT.
  - ifid_valid=0, ifid_pc=0, ifid_pc_plus4=0, ifid_instr=NOP_INSTR.
  - halted=0, fetch_count=0.
- FSM states: BOOT, RUN, HALT.
  - BOOT: exactly one bubble cycle after rst deasserts. ifid_valid<=0, pc holds. Next state RUN unconditionally; stall is ignored in BOOT.
  - RUN: per-cycle priority below.
  - HALT: ifid_valid<=0, pc holds, halted=1. Leaves only via redirect_valid (to RUN) or rst.
- Per-cycle priority in RUN (and redirect in any state except BOOT): rst > redirect_valid > flush > stall > normal fetch.
  - redirect_valid: pc<=redirect_pc, ifid_valid<=0, state<=RUN. Wins over stall, flush and HALT; counter holds.
  - flush (no redirect): ifid_valid<=0; pc holds, so the same address is refetched next cycle; counter holds. Wins over stall.
  - stall: all registers hold, including ifid_valid.
  - normal fetch: ifid_instr<=imem_rdata, ifid_pc<=pc, ifid_pc_plus4<=pc+4, ifid_valid<=1, pc<=pc+4, fetch_count<=fetch_count+1.
- EBREAK: if a normal fetch captures imem_rdata==32'h0010_0073, it is captured with valid=1 and counted, pc<=pc+4, and state<=HALT. The following cycle ifid_valid=0.
- Latency: an instruction at address A appears on ifid_* one cycle after imem_addr==A.
- Arithmetic:
  - pc+4 is modulo 2^DWIDTH; 32'hFFFF_FFFC wraps to 0.
  - fetch_count wraps 32'hFFFF_FFFF -> 0.
  - redirect_pc is used verbatim; low bits are not masked.
- Reset mid-operation: rst overrides every input in the same cycle and returns the block to the reset values above.

Optional Feature:
- Macro FETCH_MISALIGN_CHECK_EN.
- When defined:
  - Adds output misalign_err (1 bit, reset 0).
  - A redirect with redirect_pc[1:0]!=0 sets misalign_err<=1 (sticky until rst), loads pc normally, and moves the FSM to HALT instead of RUN.
- When undefined: port is absent and there is no check.

Test Plan:
- Reset then run, imem holding 0x00500093 @0, 0x00100113 @4: BOOT bubble (ifid_valid=0), then ifid_pc=0 with ifid_instr=0x00500093, next cycle ifid_pc=4; fetch_count=2.
- Stall held 3 cycles at pc=8: imem_addr stays 8; ifid_* and fetch_count unchanged; on release ifid_pc=8 next cycle.
- Redirect to 0x40 asserted together with stall and flush: next cycle ifid_valid=0, imem_addr=0x40; following cycle ifid_pc=0x40.
- EBREAK (0x00100073) at 0x10: captured with ifid_valid=1, then halted=1, ifid_valid=0, imem_addr=0x14 frozen. Redirect to 0 resumes fetch from 0 with halted=0.
- redirect_pc=32'hFFFF_FFFC, no stall: ifid_pc=0xFFFFFFFC with ifid_pc_plus4=0, and the next imem_addr=0.
- Macro defined, redirect to 0x42: misalign_err=1, halted=1. A later rst clears both, with pc=RESET_PC and ifid_instr=0x00000013.
